bin_to_bcd_seq: RTL and testbench

//  Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.

---
 rtl/alu_bcd_pkg.sv | 10 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 107 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package alu_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    localparam int         BCD_DIGIT_W    = 4;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so the next left
// shift carries into the neighbouring digit instead of producing a code > 9.
module bcd_digit_adj
    import alu_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] dig_i,
    output logic [BCD_DIGIT_W-1:0] dig_o
);

    always_comb begin
        dig_o = dig_i;
        if (dig_i >= BCD_ADJ_THRESH) begin
            dig_o = dig_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with
// optional signed input, overflow flag and valid/ready on both sides.
module bin_to_bcd_seq
    import alu_bcd_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int DIGITS = 2,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_neg,
    output logic                          out_ovf,
    output logic                          busy
);

    localparam int BW = BCD_DIGIT_W * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    bcd_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mag_q, mag_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic [BW-1:0]     bcd_adj;
    logic              in_is_neg;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .dig_i (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dig_o (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign in_is_neg = (SIGNED != 0) && in_data[WIDTH-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Negating the most negative value wraps to 2^(WIDTH-1),
                    // which is exactly the wanted unsigned magnitude.
                    mag_d   = in_is_neg ? WIDTH'(-in_data) : in_data;
                    neg_d   = in_is_neg;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                ovf_d = ovf_q | bcd_adj[BW-1];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;
    assign out_neg   = neg_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised and directed bench for bin_to_bcd_seq across four parameter sets,
// checked every cycle against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    localparam int PW[4] = '{5, 8, 8, 8};
    localparam int PD[4] = '{2, 2, 3, 3};
    localparam int PS[4] = '{0, 0, 1, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       in_valid [4];
    logic [7:0] in_data  [4];
    logic       out_ready[4];
    logic       ir[4], ov[4], bz[4], on[4], of[4];
    logic [11:0] ob[4];
    logic [7:0]  ob0, ob1;
    logic [11:0] ob2, ob3;

    assign ob[0] = {4'h0, ob0};
    assign ob[1] = {4'h0, ob1};
    assign ob[2] = ob2;
    assign ob[3] = ob3;

    bin_to_bcd_seq #(.WIDTH(5), .DIGITS(2), .SIGNED(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir[0]),
        .in_data(in_data[0][4:0]), .out_valid(ov[0]), .out_ready(out_ready[0]),
        .out_bcd(ob0), .out_neg(on[0]), .out_ovf(of[0]), .busy(bz[0]));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir[1]),
        .in_data(in_data[1]), .out_valid(ov[1]), .out_ready(out_ready[1]),
        .out_bcd(ob1), .out_neg(on[1]), .out_ovf(of[1]), .busy(bz[1]));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir[2]),
        .in_data(in_data[2]), .out_valid(ov[2]), .out_ready(out_ready[2]),
        .out_bcd(ob2), .out_neg(on[2]), .out_ovf(of[2]), .busy(bz[2]));
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(ir[3]),
        .in_data(in_data[3]), .out_valid(ov[3]), .out_ready(out_ready[3]),
        .out_bcd(ob3), .out_neg(on[3]), .out_ovf(of[3]), .busy(bz[3]));

    int vectors = 0;
    int errs    = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: {neg, ovf, bcd[39:0]} from plain decimal arithmetic.
    function automatic logic [41:0] ref_conv(input logic [7:0] v, input int w, input int d, input int s);
        longint mag, p;
        logic [39:0] bcd;
        logic neg;
        bcd = '0;
        mag = longint'(v) & ((64'd1 << w) - 1);
        neg = (s != 0) && v[w-1];
        if (neg) mag = (64'd1 << w) - mag;
        p = 1;
        for (int k = 0; k < d; k++) begin
            bcd[4*k +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        return {neg, (mag >= p), bcd};
    endfunction

    // Transaction-level model: outstanding flag and age since acceptance.
    int          cyc = 0;
    logic        m_out [4];
    int          m_age [4];
    int          m_tacc[4];
    int          m_nacc[4];
    logic [41:0] m_exp [4];

    initial for (int i = 0; i < 4; i++) m_nacc[i] = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_out[i] <= 1'b0;
                m_age[i] <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int i = 0; i < 4; i++) begin
                if (m_out[i]) begin
                    if (m_age[i] >= PW[i] && out_ready[i]) m_out[i] <= 1'b0;
                    else m_age[i] <= m_age[i] + 1;
                end else if (in_valid[i]) begin
                    m_out[i]  <= 1'b1;
                    m_age[i]  <= 0;
                    m_exp[i]  <= ref_conv(in_data[i], PW[i], PD[i], PS[i]);
                    m_tacc[i] <= cyc;
                    m_nacc[i] <= m_nacc[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                logic vexp;
                vexp = m_out[i] && (m_age[i] >= PW[i]);
                check($sformatf("u%0d in_ready", i), ir[i], !m_out[i]);
                check($sformatf("u%0d busy", i), bz[i], m_out[i] && (m_age[i] < PW[i]));
                check($sformatf("u%0d out_valid", i), ov[i], vexp);
                if (vexp) begin
                    check($sformatf("u%0d out_bcd", i), ob[i], m_exp[i][11:0]);
                    check($sformatf("u%0d out_ovf", i), of[i], m_exp[i][40]);
                    check($sformatf("u%0d out_neg", i), on[i], m_exp[i][41]);
                end
            end
        end
    end

    task automatic convert(input int i, input logic [7:0] v, input int hold, input bit junk,
                           output logic [11:0] b, output logic n, output logic o);
        int  n0;
        bit  ok;
        b = '0; n = 1'b0; o = 1'b0;
        @(negedge clk);
        n0 = m_nacc[i];
        in_valid[i] = 1'b1;
        in_data[i]  = v;
        if (hold > 0) out_ready[i] = 1'b0;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(posedge clk); #1;
            if (m_nacc[i] != n0) ok = 1;
        end
        if (!ok) check($sformatf("u%0d accept timeout", i), 0, 1);
        @(negedge clk);
        in_valid[i] = junk;
        in_data[i]  = ~v;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (ov[i]) begin
                ok = 1; b = ob[i]; n = on[i]; o = of[i];
            end else @(negedge clk);
        end
        if (!ok) check($sformatf("u%0d out_valid timeout", i), 0, 1);
        repeat (hold) @(negedge clk);
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [11:0] b;
        logic        n, o;
        logic [41:0] r;
        int          t1, n0;
        bit          ok;

        for (int i = 0; i < 4; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; out_ready[i] = 1'b1;
        end

        // Model pins
        r = ref_conv(8'd23, 5, 2, 0);   check("pin 23", r, {2'b00, 40'h23});
        r = ref_conv(8'hFF, 8, 2, 0);   check("pin 255", r, {2'b01, 40'h55});
        r = ref_conv(8'h80, 8, 3, 1);   check("pin -128", r, {2'b10, 40'h128});

        #12;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("u%0d rst in_ready", i), ir[i], 1'b1);
            check($sformatf("u%0d rst out_valid", i), ov[i], 1'b0);
            check($sformatf("u%0d rst busy", i), bz[i], 1'b0);
            check($sformatf("u%0d rst out_bcd", i), ob[i], 12'h0);
            check($sformatf("u%0d rst flags", i), {on[i], of[i]}, 2'b00);
        end
        @(negedge clk); rst_n = 1'b1;

        convert(0, 8'b10111, 0, 0, b, n, o);
        check("t1 23", {o, b}, {1'b0, 12'h023});

        // Back-to-back acceptance with out_ready held high
        @(negedge clk);
        n0 = m_nacc[0];
        in_valid[0] = 1'b1; in_data[0] = 8'b10011;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin @(posedge clk); #1; if (m_nacc[0] != n0) ok = 1; end
        t1 = m_tacc[0];
        @(negedge clk);
        in_data[0] = 8'b01001;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin @(posedge clk); #1; if (m_nacc[0] == n0 + 2) ok = 1; end
        check("t2 spacing", m_tacc[0] - t1, 7);
        @(negedge clk); in_valid[0] = 1'b0;
        repeat (10) @(negedge clk);

        convert(0, 8'd17, 6, 1, b, n, o);
        check("t3 backpressure 17", b, 12'h017);

        convert(1, 8'd255, 0, 0, b, n, o);
        check("t4 255", {o, b}, {1'b1, 12'h055});
        convert(1, 8'd99, 0, 0, b, n, o);
        check("t4 99", {o, b}, {1'b0, 12'h099});

        convert(2, 8'h80, 0, 0, b, n, o);
        check("t5 -128", {n, b}, {1'b1, 12'h128});
        convert(2, 8'hFF, 0, 0, b, n, o);
        check("t5 -1", {n, b}, {1'b1, 12'h001});
        convert(2, 8'h7F, 0, 0, b, n, o);
        check("t5 127", {n, b}, {1'b0, 12'h127});

        // Reset three cycles into SHIFT
        @(negedge clk);
        n0 = m_nacc[3];
        in_valid[3] = 1'b1; in_data[3] = 8'd77;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin @(posedge clk); #1; if (m_nacc[3] != n0) ok = 1; end
        @(negedge clk); in_valid[3] = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst in_ready", ir[3], 1'b1);
        check("t6 rst busy/valid", {bz[3], ov[3]}, 2'b00);
        check("t6 rst out_bcd", ob[3], 12'h0);
        check("t6 rst flags", {on[3], of[3]}, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        convert(3, 8'd200, 0, 0, b, n, o);
        check("t6 200", {o, b}, {1'b0, 12'h200});

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 30; k++) begin
                convert(i, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), b, n, o);
            end
        end

        for (int v = 0; v < 256; v++) begin
            convert(3, 8'(v), 0, 0, b, n, o);
            convert(2, 8'(v), 0, 0, b, n, o);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
